// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion scheduler.
//   - ADC_DATA_W : default ADC result width
//   - SDATA_CH_W : width of the channel tag that prefixes each sample
//   - state_t    : scheduler FSM encoding (also exported on the STATE port)
package adc_pkg;

    localparam int unsigned ADC_DATA_W = 18;

    // Sample word layout: {channel[SDATA_CH_W-1:0], result[DATA_W-1:0]}
    localparam int unsigned SDATA_CH_W = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CNV   = 3'd1,
        S_WBH   = 3'd2,
        S_WBL   = 3'd3,
        S_SHIFT = 3'd4,
        S_STORE = 3'd5
    } state_t;

endpackage

// File: rtl/adc_serial_shifter.sv
// Serial read-out engine for one ADC word.
//   clk, rst_n : system clock (negative-edge logic), async active-low reset
//   start      : one-cycle request; begins a read-out on the next edge
//   sdout      : serial data from the selected ADC
//   cs_n       : active-low chip select, low for the whole read-out
//   sclk       : serial clock, CLK/2, idles low
//   done       : one-cycle pulse once the word is complete
//   data       : captured word, MSB first, stable until the next start
module adc_serial_shifter
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sdout,
    output logic              cs_n,
    output logic              sclk,
    output logic              done,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    logic             active;
    logic [BIT_W-1:0] bit_cnt;

    assign cs_n = ~active;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            bit_cnt <= '0;
            data    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active  <= 1'b1;
                sclk    <= 1'b0;
                bit_cnt <= '0;
            end else if (active) begin
                if (sclk) begin
                    // Falling half: after the last rising edge, park SCLK low and finish.
                    sclk <= 1'b0;
                    if (bit_cnt == BIT_W'(DATA_W)) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end
                end else begin
                    // Rising half: capture the bit the ADC presented during the low phase.
                    sclk    <= 1'b1;
                    data    <= {data[DATA_W-2:0], sdout};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Periodic two-channel ADC conversion scheduler.
// Starts a conversion every PERIOD cycles on the next enabled channel
// (round-robin), waits for the BUSY pulse, reads the result serially and
// presents {channel, result} on a valid/ready sample port.
//   CLK, RSTN            : system clock (all logic on negedge), async active-low reset
//   EN, CH_MASK, PERIOD  : run enable, channel enables, start-to-start spacing
//   ADCNVST/ADCS/ADSCLK  : per-channel convert start, chip select (low), serial clock
//   ADBUSY/ADSDOUT       : per-channel busy and serial data from the ADCs
//   SVALID/SREADY/SDATA  : sample handshake and payload
//   OVERRUN/TMOERR       : saturating dropped-sample and BUSY-timeout counters
//   STATE                : current FSM state
module adc_conv_scheduler
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W    = ADC_DATA_W,
    parameter int unsigned CNV_PULSE = 4,
    parameter int unsigned BUSY_TMO  = 255
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         EN,
    input  logic [1:0]                   CH_MASK,
    input  logic [15:0]                  PERIOD,
    output logic [1:0]                   ADCNVST,
    output logic [1:0]                   ADCS,
    output logic [1:0]                   ADSCLK,
    input  logic [1:0]                   ADBUSY,
    input  logic [1:0]                   ADSDOUT,
    output logic                         SVALID,
    input  logic                         SREADY,
    output logic [DATA_W+SDATA_CH_W-1:0] SDATA,
    output logic [7:0]                   OVERRUN,
    output logic [7:0]                   TMOERR,
    output logic [2:0]                   STATE
);

    localparam int unsigned CNT_W = 16;

    state_t            state, state_next;
    logic [15:0]       timer;
    logic              rr;
    logic              ch;
    logic              ch_pick;
    logic [CNT_W-1:0]  cnt;
    logic              go;
    logic              pulse_done;
    logic              tmo_hit;
    logic              tmo_event;
    logic              load_ok;
    logic              busy_ch;
    logic              start_shift;
    logic              shift_done;
    logic              sh_cs_n;
    logic              sh_sclk;
    logic              sh_sdout;
    logic [DATA_W-1:0] sh_data;

    assign busy_ch     = ADBUSY[ch];
    assign sh_sdout    = ADSDOUT[ch];
    assign go          = EN && (CH_MASK != 2'b00) && (timer == 16'd0);
    assign ch_pick     = CH_MASK[rr] ? rr : ~rr;
    assign pulse_done  = (cnt == CNT_W'(CNV_PULSE - 1));
    assign tmo_hit     = (cnt == CNT_W'(BUSY_TMO - 1));
    assign tmo_event   = ((state == S_WBH) || (state == S_WBL)) && (state_next == S_IDLE);
    assign load_ok     = !SVALID || SREADY;
    assign start_shift = (state == S_WBL) && (state_next == S_SHIFT);
    assign STATE       = state;

    always_ff @(negedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ADCNVST    = '0;
        ADCS       = '1;
        ADSCLK     = '0;

        case (state)
            S_IDLE:  if (go) state_next = S_CNV;
            S_CNV:   if (pulse_done) state_next = S_WBH;
            S_WBH: begin
                if (busy_ch)      state_next = S_WBL;
                else if (tmo_hit) state_next = S_IDLE;
            end
            S_WBL: begin
                if (!busy_ch)     state_next = S_SHIFT;
                else if (tmo_hit) state_next = S_IDLE;
            end
            S_SHIFT: if (shift_done) state_next = S_STORE;
            S_STORE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Only the selected channel is ever driven; the other stays parked.
        ADCNVST[ch] = (state == S_CNV);
        ADCS[ch]    = sh_cs_n;
        ADSCLK[ch]  = sh_sclk;
    end

    always_ff @(negedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            timer <= '0;
            rr    <= 1'b0;
            ch    <= 1'b0;
            cnt   <= '0;
        end else begin
            if ((state == S_IDLE) && go) begin
                // The CNV entry cycle is the first of the PERIOD cycles, so the
                // next start lands exactly PERIOD cycles after this one.
                timer <= (PERIOD == 16'd0) ? 16'd0 : PERIOD - 16'd1;
                ch    <= ch_pick;
                rr    <= ~ch_pick;
            end else if (timer != 16'd0) begin
                timer <= timer - 16'd1;
            end
            cnt <= (state_next != state) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(negedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            SVALID  <= 1'b0;
            SDATA   <= '0;
            OVERRUN <= '0;
            TMOERR  <= '0;
        end else begin
            if ((state == S_STORE) && load_ok) begin
                SDATA  <= {ch, sh_data};
                SVALID <= 1'b1;
            end else if (SVALID && SREADY) begin
                SVALID <= 1'b0;
            end
            if ((state == S_STORE) && !load_ok && (OVERRUN != 8'hFF)) begin
                OVERRUN <= OVERRUN + 8'd1;
            end
            if (tmo_event && (TMOERR != 8'hFF)) begin
                TMOERR <= TMOERR + 8'd1;
            end
        end
    end

    adc_serial_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk   (CLK),
        .rst_n (RSTN),
        .start (start_shift),
        .sdout (sh_sdout),
        .cs_n  (sh_cs_n),
        .sclk  (sh_sclk),
        .done  (shift_done),
        .data  (sh_data)
    );

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler with a behavioural two-channel ADC:
// BUSY rises 3 cycles after ADCNVST falls and stays high 20 cycles; SDOUT
// presents the MSB when CS falls and the next bit after each SCLK rise.
module tb_adc_conv_scheduler;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        EN;
    logic [1:0]  CH_MASK;
    logic [15:0] PERIOD;
    logic [1:0]  ADCNVST;
    logic [1:0]  ADCS;
    logic [1:0]  ADSCLK;
    logic [1:0]  ADBUSY;
    logic [1:0]  ADSDOUT;
    logic        SVALID;
    logic        SREADY;
    logic [18:0] SDATA;
    logic [7:0]  OVERRUN;
    logic [7:0]  TMOERR;
    logic [2:0]  STATE;

    logic [17:0] word [2];
    logic [1:0]  stuck;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 CLK = ~CLK;

    adc_conv_scheduler #(
        .DATA_W    (18),
        .CNV_PULSE (4),
        .BUSY_TMO  (255)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .EN      (EN),
        .CH_MASK (CH_MASK),
        .PERIOD  (PERIOD),
        .ADCNVST (ADCNVST),
        .ADCS    (ADCS),
        .ADSCLK  (ADSCLK),
        .ADBUSY  (ADBUSY),
        .ADSDOUT (ADSDOUT),
        .SVALID  (SVALID),
        .SREADY  (SREADY),
        .SDATA   (SDATA),
        .OVERRUN (OVERRUN),
        .TMOERR  (TMOERR),
        .STATE   (STATE)
    );

    for (genvar c = 0; c < 2; c++) begin : g_adc
        logic [4:0]  idx   = '0;
        int unsigned rises = 0;
        logic        busy  = 1'b0;

        always @(negedge ADCS[c] or posedge ADSCLK[c]) begin
            if (ADSCLK[c]) begin
                idx   = idx + 5'd1;
                rises = rises + 1;
            end else begin
                idx = '0;
            end
        end

        assign ADSDOUT[c] = (idx < 5'd18) ? word[c][5'd17 - idx] : 1'b0;
        assign ADBUSY[c]  = busy;

        initial begin
            forever begin
                @(negedge ADCNVST[c]);
                if (!stuck[c]) begin
                    repeat (3) @(posedge CLK);
                    busy = 1'b1;
                    repeat (20) @(posedge CLK);
                    busy = 1'b0;
                end
            end
        end
    end

    int unsigned cyc     = 0;
    int unsigned cnv_hi0 = 0;
    int unsigned wbh_cyc = 0;
    int unsigned sv_cnt  = 0;
    logic        cnv_any_q = 1'b0;
    int unsigned starts[$];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ADCNVST[0]) cnv_hi0 <= cnv_hi0 + 1;
        if (STATE == 3'd2) wbh_cyc <= wbh_cyc + 1;
        if (SVALID) sv_cnt <= sv_cnt + 1;
        if ((|ADCNVST) && !cnv_any_q) starts.push_back(cyc);
        cnv_any_q <= |ADCNVST;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_svalid(input int unsigned limit, input string tag);
        int unsigned n = 0;
        while ((SVALID !== 1'b1) && (n < limit)) begin
            @(posedge CLK);
            n++;
        end
        check_eq(tag, 32'(SVALID), 32'd1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int unsigned limit, input string tag);
        int unsigned n = 0;
        while ((STATE !== s) && (n < limit)) begin
            @(posedge CLK);
            n++;
        end
        check_eq(tag, 32'(STATE), 32'(s));
    endtask

    task automatic do_reset();
        RSTN   = 1'b0;
        EN     = 1'b0;
        SREADY = 1'b0;
        repeat (3) @(posedge CLK);
        RSTN = 1'b1;
        @(posedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned c0, r0, w0, s0, n0, d1, d2;

        RSTN    = 1'b0;
        EN      = 1'b0;
        CH_MASK = 2'b00;
        PERIOD  = 16'd300;
        SREADY  = 1'b0;
        stuck   = 2'b00;
        word[0] = 18'h0;
        word[1] = 18'h0;
        repeat (3) @(posedge CLK);

        check_eq("rst_state",   32'(STATE),   32'd0);
        check_eq("rst_cnvst",   32'(ADCNVST), 32'd0);
        check_eq("rst_cs",      32'(ADCS),    32'd3);
        check_eq("rst_sclk",    32'(ADSCLK),  32'd0);
        check_eq("rst_svalid",  32'(SVALID),  32'd0);
        check_eq("rst_sdata",   32'(SDATA),   32'd0);
        check_eq("rst_overrun", 32'(OVERRUN), 32'd0);
        check_eq("rst_tmoerr",  32'(TMOERR),  32'd0);
        RSTN = 1'b1;
        @(posedge CLK);

        // Single conversion on channel 0
        word[0] = 18'h2A5A5;
        CH_MASK = 2'b01;
        c0 = cnv_hi0;
        r0 = g_adc[0].rises;
        EN = 1'b1;
        wait_svalid(1000, "t1_valid");
        EN = 1'b0;
        check_eq("t1_sdata",    32'(SDATA), 32'h2A5A5);
        check_eq("t1_cnv_len",  cnv_hi0 - c0, 32'd4);
        check_eq("t1_sclk_cnt", g_adc[0].rises - r0, 32'd18);
        check_eq("t1_cs_idle",  32'(ADCS), 32'd3);
        SREADY = 1'b1;
        repeat (2) @(posedge CLK);
        check_eq("t1_consumed", 32'(SVALID), 32'd0);

        // Round-robin over both channels
        do_reset();
        word[0] = 18'h12345;
        word[1] = 18'h0ABCD;
        CH_MASK = 2'b11;
        SREADY  = 1'b1;
        n0 = starts.size();
        EN = 1'b1;
        wait_svalid(1000, "t2_valid0");
        check_eq("t2_sample0", 32'(SDATA), 32'h12345);
        @(posedge CLK);
        wait_svalid(1000, "t2_valid1");
        check_eq("t2_sample1", 32'(SDATA), 32'h4ABCD);
        @(posedge CLK);
        wait_svalid(1000, "t2_valid2");
        check_eq("t2_sample2", 32'(SDATA), 32'h12345);
        EN = 1'b0;
        d1 = (starts.size() >= n0 + 3) ? starts[n0 + 1] - starts[n0] : 0;
        d2 = (starts.size() >= n0 + 3) ? starts[n0 + 2] - starts[n0 + 1] : 0;
        check_eq("t2_spacing1", d1, 32'd300);
        check_eq("t2_spacing2", d2, 32'd300);

        // Back-pressure: sample held, later ones dropped
        do_reset();
        word[0] = 18'h11111;
        CH_MASK = 2'b01;
        SREADY  = 1'b0;
        EN      = 1'b1;
        wait_svalid(1000, "t3_valid");
        check_eq("t3_first", 32'(SDATA), 32'h11111);
        word[0] = 18'h22222;
        repeat (700) @(posedge CLK);
        EN = 1'b0;
        check_eq("t3_overrun", 32'(OVERRUN), 32'd2);
        check_eq("t3_held",    32'(SDATA),   32'h11111);
        check_eq("t3_svalid",  32'(SVALID),  32'd1);

        // SREADY in the STORE cycle while SVALID=1: new sample wins
        EN = 1'b1;
        wait_state(3'd5, 1000, "t4_store");
        SREADY = 1'b1;
        @(posedge CLK);
        SREADY = 1'b0;
        EN     = 1'b0;
        check_eq("t4_svalid",  32'(SVALID),  32'd1);
        check_eq("t4_sdata",   32'(SDATA),   32'h22222);
        check_eq("t4_overrun", 32'(OVERRUN), 32'd2);

        // BUSY never rises: timeout, then a normal conversion
        do_reset();
        stuck   = 2'b01;
        word[0] = 18'h3C3C3;
        CH_MASK = 2'b01;
        SREADY  = 1'b1;
        w0 = wbh_cyc;
        s0 = sv_cnt;
        EN = 1'b1;
        for (int i = 0; i < 1000 && TMOERR == 8'd0; i++) @(posedge CLK);
        check_eq("t5_tmoerr",   32'(TMOERR), 32'd1);
        check_eq("t5_wbh_len",  wbh_cyc - w0, 32'd255);
        check_eq("t5_no_valid", sv_cnt - s0, 32'd0);
        stuck = 2'b00;
        wait_svalid(1000, "t5_next_valid");
        EN = 1'b0;
        check_eq("t5_next_data", 32'(SDATA),  32'h3C3C3);
        check_eq("t5_tmo_keep",  32'(TMOERR), 32'd1);

        // Reset in the middle of a channel-1 read-out
        do_reset();
        word[1] = 18'h15A5A;
        CH_MASK = 2'b10;
        SREADY  = 1'b1;
        EN      = 1'b1;
        wait_state(3'd4, 1000, "t6_shift");
        repeat (10) @(posedge CLK);
        check_eq("t6_cs_active",  32'(ADCS),      32'd1);
        check_eq("t6_unsel_sclk", 32'(ADSCLK[0]), 32'd0);
        #2;
        RSTN = 1'b0;
        EN   = 1'b0;
        #1;
        check_eq("t6_state",  32'(STATE),   32'd0);
        check_eq("t6_cnvst",  32'(ADCNVST), 32'd0);
        check_eq("t6_cs",     32'(ADCS),    32'd3);
        check_eq("t6_sclk",   32'(ADSCLK),  32'd0);
        check_eq("t6_svalid", 32'(SVALID),  32'd0);
        check_eq("t6_sdata",  32'(SDATA),   32'd0);
        repeat (3) @(posedge CLK);
        RSTN = 1'b1;
        s0 = sv_cnt;
        repeat (200) @(posedge CLK);
        check_eq("t6_no_partial", sv_cnt - s0, 32'd0);
        check_eq("t6_idle",       32'(STATE),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
